// File: rtl/instr_mem_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_mem_sync                                                  |
// | Purpose  : Synchronous instruction memory with a valid/ready fetch port,   |
// |            a LATENCY-stage read pipeline feeding a RSP_DEPTH-entry         |
// |            response FIFO, credit-based flow control, a word load port      |
// |            and a flush input for branch redirects.                         |
// | Ports    : clk, reset                  - clock, sync active-high reset     |
// |            req_valid/req_ready/req_addr - fetch request (byte address)     |
// |            rsp_valid/rsp_ready          - response handshake               |
// |            rsp_instr/rsp_addr/rsp_fault - response payload (FIFO head)     |
// |            flush                        - drop all in-flight fetches       |
// |            ld_en/ld_addr/ld_data        - word write into the array        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_mem_sync #(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 32,
    parameter  int DEPTH     = 1024,
    parameter  int LATENCY   = 1,
    parameter  int RSP_DEPTH = 4,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int             CNT_W          = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_full_credits = CNT_W'(RSP_DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [CNT_W-1:0]  r_credits;
    logic              w_accept;
    logic              w_pop;
    logic              w_oor;
    logic              w_fault;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;

    // Entry arriving at the FIFO tail this cycle (end of the read pipeline)
    logic              w_push_vld;
    logic [DATA_W-1:0] w_push_data;
    logic [ADDR_W-1:0] w_push_addr;
    logic              w_push_fault;

    // Shift-style FIFO: entry 0 is the head and drives the rsp_* ports directly
    logic [DATA_W-1:0] r_f_data  [RSP_DEPTH];
    logic [ADDR_W-1:0] r_f_addr  [RSP_DEPTH];
    logic              r_f_fault [RSP_DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_n_data  [RSP_DEPTH];
    logic [ADDR_W-1:0] w_n_addr  [RSP_DEPTH];
    logic              w_n_fault [RSP_DEPTH];
    logic [CNT_W-1:0]  w_n_count;
    logic [CNT_W-1:0]  w_cnt_after_pop;

    // Every accepted fetch owns one FIFO slot from accept until pop, so the
    // FIFO can never overflow regardless of pipeline depth.
    assign req_ready = (r_credits != '0) && !ld_en && !flush && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    // DEPTH is a power of two, so any set bit above the index field is out of range
    if (ADDR_W > IDX_W + 2) begin : g_oor
        assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oor
        assign w_oor = 1'b0;
    end

    assign w_fault   = (req_addr[1:0] != 2'b00) || w_oor;
    assign w_idx     = req_addr[IDX_W+1:2];
    // Faulting fetches return a nop (all zeros)
    assign w_rd_data = w_fault ? '0 : r_mem[w_idx];

    // Load port; req_ready is low whenever ld_en is high, so a fetch never
    // reads the same edge a word is written.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    if (LATENCY == 1) begin : g_direct
        // The array read at the accept edge lands straight in the FIFO
        assign w_push_vld   = w_accept;
        assign w_push_data  = w_rd_data;
        assign w_push_addr  = req_addr;
        assign w_push_fault = w_fault;
    end else begin : g_pipe
        localparam int STAGES = LATENCY - 1;
        logic              r_p_vld   [STAGES];
        logic [DATA_W-1:0] r_p_data  [STAGES];
        logic [ADDR_W-1:0] r_p_addr  [STAGES];
        logic              r_p_fault [STAGES];

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                for (int i = 0; i < STAGES; i++) begin
                    r_p_vld[i] <= 1'b0;
                end
            end else begin
                r_p_vld[0] <= w_accept;
                for (int i = 1; i < STAGES; i++) begin
                    r_p_vld[i] <= r_p_vld[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            r_p_data[0]  <= w_rd_data;
            r_p_addr[0]  <= req_addr;
            r_p_fault[0] <= w_fault;
            for (int i = 1; i < STAGES; i++) begin
                r_p_data[i]  <= r_p_data[i-1];
                r_p_addr[i]  <= r_p_addr[i-1];
                r_p_fault[i] <= r_p_fault[i-1];
            end
        end

        assign w_push_vld   = r_p_vld[STAGES-1];
        assign w_push_data  = r_p_data[STAGES-1];
        assign w_push_addr  = r_p_addr[STAGES-1];
        assign w_push_fault = r_p_fault[STAGES-1];
    end

    // FIFO next state: shift down on pop (vacated top slot zeroed so an empty
    // FIFO presents zeros), then write the incoming entry at the first free slot.
    always_comb begin
        w_cnt_after_pop = r_count - CNT_W'(w_pop);
        for (int i = 0; i < RSP_DEPTH; i++) begin
            w_n_data[i]  = r_f_data[i];
            w_n_addr[i]  = r_f_addr[i];
            w_n_fault[i] = r_f_fault[i];
        end
        if (w_pop) begin
            for (int i = 0; i < RSP_DEPTH - 1; i++) begin
                w_n_data[i]  = r_f_data[i+1];
                w_n_addr[i]  = r_f_addr[i+1];
                w_n_fault[i] = r_f_fault[i+1];
            end
            w_n_data[RSP_DEPTH-1]  = '0;
            w_n_addr[RSP_DEPTH-1]  = '0;
            w_n_fault[RSP_DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < RSP_DEPTH; i++) begin
            if (w_push_vld && (w_cnt_after_pop == CNT_W'(i))) begin
                w_n_data[i]  = w_push_data;
                w_n_addr[i]  = w_push_addr;
                w_n_fault[i] = w_push_fault;
            end
        end
        w_n_count = w_cnt_after_pop + CNT_W'(w_push_vld);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_f_data[i]  <= '0;
                r_f_addr[i]  <= '0;
                r_f_fault[i] <= 1'b0;
            end
        end else begin
            r_count <= w_n_count;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_f_data[i]  <= w_n_data[i];
                r_f_addr[i]  <= w_n_addr[i];
                r_f_fault[i] <= w_n_fault[i];
            end
        end
    end

    // A pop during flush is delivered; its credit is covered by the full refill.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_credits <= c_full_credits;
        end else begin
            r_credits <= r_credits - CNT_W'(w_accept) + CNT_W'(w_pop);
        end
    end

    assign rsp_valid = (r_count != '0);
    assign rsp_instr = r_f_data[0];
    assign rsp_addr  = r_f_addr[0];
    assign rsp_fault = r_f_fault[0];

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_mem_sync                                               |
// | Purpose  : Directed, table-driven self-checking bench for instr_mem_sync   |
// |            (LATENCY=1, RSP_DEPTH=4, DEPTH=1024).                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_instr_mem_sync;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int LATENCY   = 1;
    localparam int RSP_DEPTH = 4;
    localparam int IDX_W     = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_fault;
    logic              flush;
    logic              ld_en;
    logic [IDX_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    vec_t        v [9];
    logic [31:0] prog [4];

    always #5 clk = ~clk;

    instr_mem_sync #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .LATENCY  (LATENCY),
        .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr (rsp_addr),
        .rsp_fault(rsp_fault),
        .flush    (flush),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = IDX_W'(idx);
        ld_data = data;
        #1;
        chk("ld_blocks_ready", 32'(req_ready), 32'd0);
        step();
        ld_en = 1'b0;
    endtask

    // Hold req_valid high for ncyc cycles and return how many were accepted
    task automatic fill(input int ncyc, output int acc);
        acc       = 0;
        req_valid = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            req_addr = 32'(acc * 4);
            #1;
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        prog[0] = 32'h2008_0001;
        prog[1] = 32'h2009_0002;
        prog[2] = 32'h0109_5020;
        prog[3] = 32'hAC0A_0000;

        v[0] = '{addr: 32'h0000_0000, instr: 32'h2008_0001, fault: 1'b0};
        v[1] = '{addr: 32'h0000_0004, instr: 32'h2009_0002, fault: 1'b0};
        v[2] = '{addr: 32'h0000_0008, instr: 32'h0109_5020, fault: 1'b0};
        v[3] = '{addr: 32'h0000_000C, instr: 32'hAC0A_0000, fault: 1'b0};
        v[4] = '{addr: 32'h0000_0002, instr: 32'h0000_0000, fault: 1'b1};
        v[5] = '{addr: 32'h0000_1000, instr: 32'h0000_0000, fault: 1'b1};
        v[6] = '{addr: 32'h0000_0FFC, instr: 32'h1234_5678, fault: 1'b0};
        v[7] = '{addr: 32'hFFFF_FFFC, instr: 32'h0000_0000, fault: 1'b1};
        v[8] = '{addr: 32'h0000_0007, instr: 32'h0000_0000, fault: 1'b1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        // Reset state
        step();
        step();
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_instr", rsp_instr, 32'd0);
        chk("reset_rsp_addr",  rsp_addr,  32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", 32'(req_ready), 32'd1);

        // Program load
        for (int i = 0; i < 4; i++) load(i, prog[i]);
        load(DEPTH - 1, 32'h1234_5678);

        // Back-to-back fetch table: one response per cycle, LATENCY=1
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1;
            req_addr  = v[i].addr;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'd1);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("tbl%0d_instr", i), rsp_instr, v[i].instr);
            chk($sformatf("tbl%0d_addr", i),  rsp_addr,  v[i].addr);
            chk($sformatf("tbl%0d_fault", i), 32'(rsp_fault), 32'(v[i].fault));
        end
        req_valid = 1'b0;
        step();
        chk("tbl_drained", 32'(rsp_valid), 32'd0);

        // Backpressure: exactly RSP_DEPTH accepts, outputs hold, then drain in order
        rsp_ready = 1'b0;
        fill(8, acc);
        chk("full_accepts", 32'(acc), 32'(RSP_DEPTH));
        chk("full_not_ready", 32'(req_ready), 32'd0);
        chk("hold_instr", rsp_instr, prog[0]);
        chk("hold_addr",  rsp_addr,  32'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("pop_cycle_not_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        for (int i = 0; i < RSP_DEPTH; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("drain%0d_instr", i), rsp_instr, prog[i]);
            chk($sformatf("drain%0d_addr", i),  rsp_addr,  32'(i * 4));
            step();
            chk($sformatf("drain%0d_ready_after", i), 32'(req_ready), 32'd1);
        end
        chk("drain_empty", 32'(rsp_valid), 32'd0);

        // Flush: three in flight, then flush; nothing comes back, credits refill
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(i * 4);
            #1;
            chk($sformatf("pre_flush%0d_ready", i), 32'(req_ready), 32'd1);
            step();
        end
        flush = 1'b1;
        #1;
        chk("flush_blocks_ready", 32'(req_ready), 32'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("flush_rsp_valid0", 32'(rsp_valid), 32'd0);
        step();
        chk("flush_rsp_valid1", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        fill(6, acc);
        chk("flush_credits", 32'(acc), 32'(RSP_DEPTH));
        // Flush together with a pop and a load: both take effect
        flush     = 1'b1;
        rsp_ready = 1'b1;
        ld_en     = 1'b1;
        ld_addr   = IDX_W'(5);
        ld_data   = 32'hCAFE_0005;
        step();
        flush     = 1'b0;
        ld_en     = 1'b0;
        #1;
        chk("flush2_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush2_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0014;
        step();
        req_valid = 1'b0;
        chk("flush_ld_word", rsp_instr, 32'hCAFE_0005);
        step();

        // Load-port ordering: fetch before write sees old word, after sees new
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0008;
        step();
        req_valid = 1'b0;
        ld_en     = 1'b1;
        ld_addr   = IDX_W'(2);
        ld_data   = 32'hDEAD_BEEF;
        #1;
        chk("ld_old_valid", 32'(rsp_valid), 32'd1);
        chk("ld_old_word", rsp_instr, 32'h0109_5020);
        step();
        ld_en     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0008;
        #1;
        chk("ld_then_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("ld_new_valid", 32'(rsp_valid), 32'd1);
        chk("ld_new_word", rsp_instr, 32'hDEAD_BEEF);
        step();

        // Reset with FIFO half full drops everything
        rsp_ready = 1'b0;
        fill(2, acc);
        chk("half_accepts", 32'(acc), 32'd2);
        reset     = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_pending", 32'(rsp_valid), 32'd1);
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_instr", rsp_instr, 32'd0);
        chk("rst_mid_addr",  rsp_addr,  32'd0);
        chk("rst_mid_fault", 32'(rsp_fault), 32'd0);
        chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        step();
        chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
